// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer: BOOT/RUN/HALT control, OS/user mode tracking,
// syscall entry / OS return, stall hold and a retired-instruction counter.
module pc_sequencer #(
    parameter int ADDR_W    = 12,
    parameter int OS_ENTRY  = 0,
    parameter int USER_BASE = 512,
    parameter int RET_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] target,
    input  logic              redirect,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              syscall,
    input  logic              os_return,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              os_mode,
    output logic [ADDR_W-1:0] saved_user_pc,
    output logic [RET_W-1:0]  retired
);

    localparam logic [ADDR_W-1:0] OS_PC   = ADDR_W'(OS_ENTRY);
    localparam logic [ADDR_W-1:0] USER_PC = ADDR_W'(USER_BASE);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, sup_nxt;
    logic              os_nxt;
    logic [RET_W-1:0]  ret_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= OS_PC;
            pc_valid      <= 1'b0;
            os_mode       <= 1'b1;
            saved_user_pc <= USER_PC;
            retired       <= '0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            pc_valid      <= (state_nxt == RUN);
            os_mode       <= os_nxt;
            saved_user_pc <= sup_nxt;
            retired       <= ret_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (!stall && halt_req) state_nxt = HALT;
            HALT:    if (resume) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Datapath next values; mode-switch requests that don't match the current mode
    // drop through to redirect / sequential fetch.
    always_comb begin
        pc_nxt  = pc;
        os_nxt  = os_mode;
        sup_nxt = saved_user_pc;
        ret_nxt = retired;
        case (state)
            BOOT: pc_nxt = OS_PC;
            RUN: begin
                if (!stall && !halt_req) begin
                    ret_nxt = retired + 1'b1;
                    if (syscall && !os_mode) begin
                        sup_nxt = pc + 1'b1;
                        pc_nxt  = OS_PC;
                        os_nxt  = 1'b1;
                    end else if (os_return && os_mode) begin
                        pc_nxt = saved_user_pc;
                        os_nxt = 1'b0;
                    end else if (redirect) begin
                        pc_nxt = target;
                    end else begin
                        pc_nxt = pc + 1'b1;
                    end
                end
            end
            HALT: if (resume) pc_nxt = pc + 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main RUN/HALT flow plus
// hand-written sequences for long halt, async reset and counter/PC wrap.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] target;
    logic        redirect, stall, halt_req, resume, syscall, os_return;
    logic [11:0] pc, saved_user_pc;
    logic        pc_valid, os_mode;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .target(target), .redirect(redirect), .stall(stall),
        .halt_req(halt_req), .resume(resume), .syscall(syscall), .os_return(os_return),
        .pc(pc), .pc_valid(pc_valid), .os_mode(os_mode), .saved_user_pc(saved_user_pc),
        .retired(retired)
    );

    typedef struct {
        int stall, redirect, target, halt_req, resume, syscall, os_return;
        int e_pc, e_valid, e_os, e_sup, e_ret;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_pc, input int e_valid, input int e_os,
                           input int e_sup, input int e_ret);
        chk({tag, " pc"},            32'(pc),            e_pc);
        chk({tag, " pc_valid"},      32'(pc_valid),      e_valid);
        chk({tag, " os_mode"},       32'(os_mode),       e_os);
        chk({tag, " saved_user_pc"}, 32'(saved_user_pc), e_sup);
        chk({tag, " retired"},       32'(retired),       e_ret);
    endtask

    task automatic drive(input int st, input int rd, input int tg, input int hr, input int rs,
                         input int sc, input int orr);
        stall     = st[0];
        redirect  = rd[0];
        target    = 12'(tg);
        halt_req  = hr[0];
        resume    = rs[0];
        syscall   = sc[0];
        os_return = orr[0];
    endtask

    initial begin
        //           st rd tgt  hr rs sc or   pc  vld os sup  ret
        vecs[0]  = '{0, 1, 99,  0, 0, 0, 0,   0,   1, 1, 512, 0};  // BOOT ignores inputs
        vecs[1]  = '{0, 0, 0,   0, 0, 0, 0,   1,   1, 1, 512, 1};
        vecs[2]  = '{0, 0, 0,   0, 0, 0, 0,   2,   1, 1, 512, 2};
        vecs[3]  = '{0, 0, 0,   0, 0, 1, 0,   3,   1, 1, 512, 3};  // syscall in OS ignored
        vecs[4]  = '{0, 0, 0,   0, 0, 0, 1,   512, 1, 0, 512, 4};
        vecs[5]  = '{0, 1, 520, 0, 0, 0, 0,   520, 1, 0, 512, 5};
        vecs[6]  = '{0, 1, 900, 0, 0, 1, 0,   0,   1, 1, 521, 6};  // syscall beats redirect
        vecs[7]  = '{1, 0, 0,   0, 0, 0, 1,   0,   1, 1, 521, 6};
        vecs[8]  = '{0, 0, 0,   0, 0, 0, 1,   521, 1, 0, 521, 7};
        vecs[9]  = '{0, 1, 10,  0, 0, 0, 1,   10,  1, 0, 521, 8};  // os_return in user ignored
        vecs[10] = '{1, 1, 300, 0, 0, 0, 0,   10,  1, 0, 521, 8};
        vecs[11] = '{0, 1, 300, 0, 0, 0, 0,   300, 1, 0, 521, 9};
        vecs[12] = '{0, 1, 700, 0, 0, 0, 0,   700, 1, 0, 521, 10};
        vecs[13] = '{0, 0, 0,   1, 0, 0, 0,   700, 0, 0, 521, 10};
        vecs[14] = '{1, 1, 5,   0, 0, 1, 0,   700, 0, 0, 521, 10};
        vecs[15] = '{0, 0, 0,   0, 0, 0, 1,   700, 0, 0, 521, 10};
        vecs[16] = '{0, 0, 0,   0, 1, 0, 0,   701, 1, 0, 521, 10};
        vecs[17] = '{1, 0, 0,   1, 0, 0, 0,   701, 1, 0, 521, 10}; // stall beats halt
        vecs[18] = '{0, 1, 4095,0, 0, 0, 0,   4095,1, 0, 521, 11};
        vecs[19] = '{0, 0, 0,   0, 0, 0, 0,   0,   1, 0, 521, 12}; // pc wrap
        vecs[20] = '{0, 0, 0,   1, 0, 1, 0,   0,   0, 0, 521, 12}; // halt beats syscall
        vecs[21] = '{0, 0, 0,   0, 1, 0, 0,   1,   1, 0, 521, 12};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 0, 0, 1, 512, 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].target, vecs[i].halt_req,
                  vecs[i].resume, vecs[i].syscall, vecs[i].os_return);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_os,
                       vecs[i].e_sup, vecs[i].e_ret);
        end

        // Long halt with noisy inputs
        @(negedge clk); drive(0, 1, 700, 0, 0, 0, 0);
        @(posedge clk); #1 chk_all("goto700", 700, 1, 0, 521, 13);
        @(negedge clk); drive(0, 0, 0, 1, 0, 0, 0);
        @(posedge clk); #1 chk_all("halt", 700, 0, 0, 521, 13);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); drive(i & 1, 1, i * 7, 0, 0, (i >> 1) & 1, (i >> 2) & 1);
            @(posedge clk);
            #1 chk_all($sformatf("halted%0d", i), 700, 0, 0, 521, 13);
        end
        @(negedge clk); drive(0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1 chk_all("resume", 701, 1, 0, 521, 13);

        // Async reset mid-RUN at pc=37
        @(negedge clk); drive(0, 1, 37, 0, 0, 0, 0);
        @(posedge clk); #1 chk("pre-reset pc", 32'(pc), 37);
        #2 rst_n = 1'b0;
        #1 chk_all("async reset", 0, 0, 1, 512, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 chk_all("boot", 0, 0, 1, 512, 0);
        @(posedge clk); #1 chk_all("run0", 0, 1, 1, 512, 0);
        for (int k = 1; k <= 65536; k++) begin
            @(posedge clk);
            #1;
            if (k <= 3 || k == 4095 || k == 4096 || k == 65535 || k == 65536)
                chk_all($sformatf("count%0d", k), k % 4096, 1, 1, 512, k % 65536);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
